// File: rtl/id_stage.sv
// rtl/id_stage.sv - registered RISC-V decode stage with 2-entry skid buffer and flush
// Optional illegal-encoding detection: define ID_STAGE_ILLEGAL_EN.
module id_stage #(
  parameter int          XLEN        = 64,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MTVEC   = 12'h305,
  parameter logic [11:0] CSR_MEPC    = 12'h341
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [11:0]     op_d,
  output logic [7:0]      fu3_d,
  output logic [4:0]      fu7_d,
  output logic [2:0]      e_inst,
  output logic [1:0]      csr_idx,
  output logic            illegal
);

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] MRET_WORD   = 32'h3020_0073;

  logic            m_valid, s_valid;
  logic [XLEN-1:0] m_pc, s_pc;
  logic [31:0]     m_inst, s_inst;
  logic            pop, push;

  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign pop       = m_valid && out_ready;
  assign push      = in_valid && !s_valid;

  // Skid entry only ever fills while M is stalled, so a pop with S full never coincides with a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_pc    <= '0;
      s_pc    <= '0;
      m_inst  <= '0;
      s_inst  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (pop) begin
      if (s_valid) begin
        m_pc    <= s_pc;
        m_inst  <= s_inst;
        s_valid <= 1'b0;
      end else if (push) begin
        m_pc   <= in_pc;
        m_inst <= in_inst;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (push) begin
      if (!m_valid) begin
        m_valid <= 1'b1;
        m_pc    <= in_pc;
        m_inst  <= in_inst;
      end else begin
        s_valid <= 1'b1;
        s_pc    <= in_pc;
        s_inst  <= in_inst;
      end
    end
  end

  logic [6:0]        opc, f7;
  logic [11:0]       op_c;
  logic [7:0]        fu3_c;
  logic [4:0]        fu7_c;
  logic signed [31:0] imm_sel;
  logic [XLEN-1:0]   imm_c;
  logic [2:0]        e_c;
  logic [1:0]        csr_c;
  logic              ill_c;

  assign opc = m_inst[6:0];
  assign f7  = m_inst[31:25];

  always_comb begin
    op_c     = '0;
    op_c[0]  = (opc == 7'b0110111);
    op_c[1]  = (opc == 7'b0010111);
    op_c[2]  = (opc == 7'b1101111);
    op_c[3]  = (opc == 7'b1100111);
    op_c[4]  = (opc == 7'b1100011);
    op_c[5]  = (opc == 7'b0000011);
    op_c[6]  = (opc == 7'b0100011);
    op_c[7]  = (opc == 7'b0010011);
    op_c[8]  = (opc == 7'b0110011);
    op_c[9]  = (opc == 7'b1110011);
    op_c[10] = (opc == 7'b0011011) && (XLEN > 32);
    op_c[11] = (opc == 7'b0111011) && (XLEN > 32);

    fu3_c = 8'd1 << m_inst[14:12];
    fu7_c = {f7[6:1] == 6'b010000, f7[6:1] == 6'b000000,
             f7 == 7'b0000001, f7 == 7'b0100000, f7 == 7'b0000000};

    // Every format fits in 32 signed bits; the size cast sign-extends to XLEN.
    imm_sel = '0;
    if (op_c[3] || op_c[5] || op_c[7] || op_c[9] || op_c[10])
      imm_sel = {{20{m_inst[31]}}, m_inst[31:20]};
    else if (op_c[6])
      imm_sel = {{20{m_inst[31]}}, m_inst[31:25], m_inst[11:7]};
    else if (op_c[4])
      imm_sel = {{20{m_inst[31]}}, m_inst[7], m_inst[30:25], m_inst[11:8], 1'b0};
    else if (op_c[0] || op_c[1])
      imm_sel = {m_inst[31:12], 12'b0};
    else if (op_c[2])
      imm_sel = {{12{m_inst[31]}}, m_inst[19:12], m_inst[20], m_inst[30:21], 1'b0};
    imm_c = XLEN'(imm_sel);

    e_c = {m_inst == MRET_WORD, m_inst == ECALL_WORD, m_inst == EBREAK_WORD};

`ifdef ID_STAGE_ILLEGAL_EN
    ill_c = (op_c == 12'd0)
         || (((opc == 7'b0011011) || (opc == 7'b0111011)) && (XLEN == 32))
         || ((op_c[8] || op_c[11]) && (fu7_c[2:0] == 3'b000));
    if (ill_c) begin
      op_c  = '0;
      e_c   = '0;
      imm_c = '0;
    end
`else
    ill_c = 1'b0;
`endif

    if ((imm_c[11:0] == CSR_MSTATUS) && op_c[9])
      csr_c = 2'd0;
    else if ((imm_c[11:0] == CSR_MTVEC) || e_c[1])
      csr_c = 2'd1;
    else if ((imm_c[11:0] == CSR_MEPC) || e_c[2])
      csr_c = 2'd2;
    else
      csr_c = 2'd3;
  end

  // An empty stage presents all-zero fields rather than a decode of stale storage.
  assign out_pc  = m_valid ? m_pc           : '0;
  assign rs1     = m_valid ? m_inst[19:15]  : '0;
  assign rs2     = m_valid ? m_inst[24:20]  : '0;
  assign rd      = m_valid ? m_inst[11:7]   : '0;
  assign imm     = m_valid ? imm_c          : '0;
  assign op_d    = m_valid ? op_c           : '0;
  assign fu3_d   = m_valid ? fu3_c          : '0;
  assign fu7_d   = m_valid ? fu7_c          : '0;
  assign e_inst  = m_valid ? e_c            : '0;
  assign csr_idx = m_valid ? csr_c          : '0;
  assign illegal = m_valid ? ill_c          : 1'b0;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized and directed bench for id_stage at XLEN=64 and XLEN=32
module tb_id_stage;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;

  logic        in_ready_64, out_valid_64, illegal_64;
  logic [63:0] out_pc_64, imm_64;
  logic [4:0]  rs1_64, rs2_64, rd_64, fu7_d_64;
  logic [11:0] op_d_64;
  logic [7:0]  fu3_d_64;
  logic [2:0]  e_inst_64;
  logic [1:0]  csr_idx_64;

  logic        in_ready_32, out_valid_32, illegal_32;
  logic [31:0] out_pc_32, imm_32;
  logic [4:0]  rs1_32, rs2_32, rd_32, fu7_d_32;
  logic [11:0] op_d_32;
  logic [7:0]  fu3_d_32;
  logic [2:0]  e_inst_32;
  logic [1:0]  csr_idx_32;

  id_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_64),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid_64), .out_ready(out_ready),
    .out_pc(out_pc_64), .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .imm(imm_64),
    .op_d(op_d_64), .fu3_d(fu3_d_64), .fu7_d(fu7_d_64), .e_inst(e_inst_64),
    .csr_idx(csr_idx_64), .illegal(illegal_64)
  );

  id_stage #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_32),
    .in_pc(in_pc[31:0]), .in_inst(in_inst), .out_valid(out_valid_32), .out_ready(out_ready),
    .out_pc(out_pc_32), .rs1(rs1_32), .rs2(rs2_32), .rd(rd_32), .imm(imm_32),
    .op_d(op_d_32), .fu3_d(fu3_d_32), .fu7_d(fu7_d_32), .e_inst(e_inst_32),
    .csr_idx(csr_idx_32), .illegal(illegal_32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } beat_t;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [11:0] op;
    logic [7:0]  fu3;
    logic [4:0]  fu7;
    logic [2:0]  e;
    logic [1:0]  csr;
    logic        ill;
  } dec_t;

  beat_t       q[$];
  logic [63:0] popped[$];
  int          errors = 0;
  int          checks = 0;
  bit          last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode straight from the ISA field tables using integer arithmetic.
  function automatic dec_t ref_dec(input logic [31:0] i, input int xlen);
    dec_t        d;
    int          cls;
    longint      s, v;
    logic [6:0]  f7;
    d = '{default: 0};
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.rd  = i[11:7];
    case (i[6:0])
      7'h37: cls = 0;   7'h17: cls = 1;   7'h6F: cls = 2;   7'h67: cls = 3;
      7'h63: cls = 4;   7'h03: cls = 5;   7'h23: cls = 6;   7'h13: cls = 7;
      7'h33: cls = 8;   7'h73: cls = 9;   7'h1B: cls = 10;  7'h3B: cls = 11;
      default: cls = -1;
    endcase
    if (xlen == 32 && cls >= 10) cls = -1;
    if (cls >= 0) d.op = 12'd1 << cls;
    d.fu3 = 8'd1 << i[14:12];
    f7 = i[31:25];
    d.fu7 = {f7[6:1] == 6'd16, f7[6:1] == 6'd0, f7 == 7'd1, f7 == 7'd32, f7 == 7'd0};
    s = longint'(signed'(i));
    case (cls)
      3, 5, 7, 9, 10: v = s >>> 20;
      6:    v = ((s >>> 25) << 5) | longint'(i[11:7]);
      4:    v = ((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5)
                | (longint'(i[11:8]) << 1);
      0, 1: v = s & ~longint'(64'hFFF);
      2:    v = ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11)
                | (longint'(i[30:21]) << 1);
      default: v = 0;
    endcase
    d.imm = v;
    if (xlen == 32) d.imm[63:32] = '0;
    if (i == 32'h00100073) d.e = 3'b001;
    else if (i == 32'h00000073) d.e = 3'b010;
    else if (i == 32'h30200073) d.e = 3'b100;
`ifdef ID_STAGE_ILLEGAL_EN
    d.ill = (d.op == 0) || ((cls == 8 || cls == 11) && d.fu7[2:0] == 0);
    if (d.ill) begin
      d.op  = '0;
      d.e   = '0;
      d.imm = '0;
    end
`endif
    if (d.imm[11:0] == 12'h300 && d.op[9]) d.csr = 2'd0;
    else if (d.imm[11:0] == 12'h305 || d.e == 3'b010) d.csr = 2'd1;
    else if (d.imm[11:0] == 12'h341 || d.e == 3'b100) d.csr = 2'd2;
    else d.csr = 2'd3;
    return d;
  endfunction

  task automatic check_all();
    dec_t        d64, d32;
    logic [63:0] pc;
    d64 = '{default: 0};
    d32 = '{default: 0};
    pc  = '0;
    if (q.size() > 0) begin
      d64 = ref_dec(q[0].inst, 64);
      d32 = ref_dec(q[0].inst, 32);
      pc  = q[0].pc;
    end
    chk("in_ready64",  in_ready_64,  q.size() < 2);
    chk("out_valid64", out_valid_64, q.size() > 0);
    chk("out_pc64",    out_pc_64,    pc);
    chk("regs64",      {rs1_64, rs2_64, rd_64}, {d64.rs1, d64.rs2, d64.rd});
    chk("imm64",       imm_64,       d64.imm);
    chk("op_d64",      op_d_64,      d64.op);
    chk("fu_d64",      {fu3_d_64, fu7_d_64}, {d64.fu3, d64.fu7});
    chk("sys64",       {e_inst_64, csr_idx_64, illegal_64}, {d64.e, d64.csr, d64.ill});
    chk("in_ready32",  in_ready_32,  q.size() < 2);
    chk("out_valid32", out_valid_32, q.size() > 0);
    chk("out_pc32",    out_pc_32,    pc[31:0]);
    chk("regs32",      {rs1_32, rs2_32, rd_32}, {d32.rs1, d32.rs2, d32.rd});
    chk("imm32",       imm_32,       d32.imm);
    chk("op_d32",      op_d_32,      d32.op);
    chk("fu_d32",      {fu3_d_32, fu7_d_32}, {d32.fu3, d32.fu7});
    chk("sys32",       {e_inst_32, csr_idx_32, illegal_32}, {d32.e, d32.csr, d32.ill});
  endtask

  task automatic step(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                      input bit ordy, input bit fl);
    int    pre;
    bit    pop, push;
    beat_t b;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    pre  = q.size();
    pop  = (pre > 0) && ordy;
    push = v && (pre < 2);
    if (out_valid_64 && ordy && !fl) popped.push_back(out_pc_64);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        b.pc   = pc;
        b.inst = inst;
        q.push_back(b);
      end
    end
    last_acc = push && !fl;
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 17);
    case (k)
      0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6F;  3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;  6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;
      8: r[6:0] = 7'h33;  9: r[6:0] = 7'h73;  10: r[6:0] = 7'h1B; 11: r[6:0] = 7'h3B;
      12: r = 32'h00100073;
      13: r = 32'h00000073;
      14: r = 32'h30200073;
      15: r = 32'h30002573;
      16: r = ($urandom_range(0, 1) == 0) ? 32'h30529073 : 32'h34102573;
      default: ;
    endcase
    return r;
  endfunction

  localparam logic [31:0] ADDI = 32'hFFF10093;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #12;
    check_all();
    chk("rst_in_ready", in_ready_64, 1'b1);
    chk("rst_csr_idx",  csr_idx_64, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 64'h1000, ADDI, 1, 0);
    chk("addi_rs1", rs1_64, 5'd2);
    chk("addi_rd",  rd_64, 5'd1);
    chk("addi_imm", imm_64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_op",  op_d_64, 12'h080);
    chk("addi_fu3", fu3_d_64, 8'h01);

    step(1, 64'h1004, 32'h800002B7, 1, 0);
    chk("lui_imm64", imm_64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", imm_32, 32'h8000_0000);
    chk("lui_op",    op_d_64, 12'h001);

    step(1, 64'h1008, 32'h00000073, 1, 0);
    chk("ecall_e",   e_inst_64, 3'b010);
    chk("ecall_csr", csr_idx_64, 2'd1);
    step(1, 64'h100C, 32'h30200073, 1, 0);
    chk("mret_e",    e_inst_64, 3'b100);
    chk("mret_csr",  csr_idx_64, 2'd2);
    step(1, 64'h1010, 32'h30002573, 1, 0);
    chk("csrrs_csr", csr_idx_64, 2'd0);

    step(1, 64'h1014, 32'h0000007F, 1, 0);
    step(1, 64'h1018, 32'h0010809B, 1, 0);
    chk("addiw_op64", op_d_64, 12'h400);
    chk("addiw_op32", op_d_32, 12'h000);
`ifdef ID_STAGE_ILLEGAL_EN
    chk("addiw_ill32", illegal_32, 1'b1);
`else
    chk("addiw_ill32", illegal_32, 1'b0);
`endif
    step(0, 64'h0, 32'h0, 1, 0);

    // Backpressure: two accepts fill the stage, then release and drain in order.
    popped.delete();
    step(1, 64'h0, ADDI, 0, 0);
    chk("bp_ready1", in_ready_64, 1'b1);
    step(1, 64'h4, ADDI, 0, 0);
    chk("bp_ready2", in_ready_64, 1'b0);
    step(1, 64'h8, ADDI, 0, 0);
    chk("bp_hold_pc", out_pc_64, 64'h0);
    begin
      int idx = 2;
      for (int c = 0; c < 4; c++) begin
        step(idx < 4, 64'(idx * 4), ADDI, 1, 0);
        if (last_acc) idx++;
      end
    end
    chk("bp_count", popped.size(), 4);
    for (int k = 0; k < 4 && k < popped.size(); k++) chk("bp_order", popped[k], 64'(k * 4));

    // Flush with two held beats, and with one held beat plus an acceptable input.
    popped.delete();
    step(1, 64'h200, ADDI, 0, 0);
    step(1, 64'h204, ADDI, 0, 0);
    step(1, 64'h208, ADDI, 0, 1);
    chk("fl_valid", out_valid_64, 1'b0);
    chk("fl_ready", in_ready_64, 1'b1);
    step(1, 64'h300, ADDI, 0, 0);
    step(1, 64'h304, ADDI, 1, 1);
    chk("fl2_valid", out_valid_64, 1'b0);
    step(0, 64'h0, 32'h0, 1, 0);
    step(0, 64'h0, 32'h0, 1, 0);
    chk("fl_no_pop", popped.size(), 0);

    // Asynchronous reset mid-stream.
    step(1, 64'h400, ADDI, 0, 0);
    step(1, 64'h404, ADDI, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_valid", out_valid_64, 1'b0);
    chk("arst_ready", in_ready_64, 1'b1);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 64'h0, 32'h0, 1, 0);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, {$urandom, $urandom}, rand_inst(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Registered, handshaked RISC-V decode stage that replaces the purely combinational decoder.
- Sits between IF and EX. Accepts {pc, inst} beats and emits decoded fields: registers, immediate, one-hot opcode/funct classes, system-instruction flags, CSR index.
- Generalised over XLEN (32/64). Adds valid/ready backpressure through a 2-entry skid buffer, plus a synchronous flush.

Parameters:
- XLEN, 64, datapath width (32 or 64); sets imm and pc width and RV64-only opcode legality.
- CSR_MSTATUS, 12'h300, CSR address mapped to csr_idx 0.
- CSR_MTVEC, 12'h305, CSR address mapped to csr_idx 1.
- CSR_MEPC, 12'h341, CSR address mapped to csr_idx 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_pc  in  XLEN  instruction address
- in_inst  in  32  instruction word
- out_valid  out  1  decoded beat valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  pc of emitted beat
- rs1, rs2, rd  out  5 each  inst[19:15], inst[24:20], inst[11:7]
- imm  out  XLEN  sign-extended immediate
- op_d  out  12  one-hot opcode class
- fu3_d  out  8  one-hot funct3
- fu7_d  out  5  funct7 class flags
- e_inst  out  3  ebreak=001, ecall=010, mret=100, else 000
- csr_idx  out  2  CSR file index
- illegal  out  1  unsupported encoding (optional feature)

Behaviour:
- Reset (rst_n=0, async): both entries empty; out_valid=0, in_ready=1; all data outputs 0.
- Storage: main entry M drives the outputs; skid entry S holds overflow. Decoded fields are a pure function of M's {pc, inst}.
- Handshake: a transfer occurs on a clock edge when valid and ready are both high. Latency 1 cycle, so a beat accepted at edge n is visible at the outputs after edge n.
- in_ready = !S_full (registered, no combinational path from out_ready).
- Accept with M empty, or with M popping this cycle and S empty: the beat goes to M.
- Accept with M full and not popping: the beat goes to S.
- On an M pop with S full: S moves to M and S empties.
- Ordering is strictly FIFO. No beat is lost or duplicated. Full 1-beat/cycle throughput is sustained when out_ready=1.
- out_valid/out_pc/decoded fields stay stable while out_valid=1 and out_ready=0.
- flush: at the edge, M and S both empty and any in_valid beat in the same cycle is dropped. flush has priority over all transfers. in_ready is 1 on the cycle after a flush.
- op_d bits, by opcode:
  - [0] 0110111, [1] 0010111, [2] 1101111, [3] 1100111
  - [4] 1100011, [5] 0000011, [6] 0100011, [7] 0010011
  - [8] 0110011, [9] 1110011, [10] 0011011, [11] 0111011
  - Bits [10] and [11] are forced 0 when XLEN=32.
- fu3_d: one-hot of inst[14:12].
- fu7_d: [0] f7==0000000, [1] f7==0100000, [2] f7==0000001, [3] f7[6:1]==000000, [4] f7[6:1]==010000.
- imm by class; all formats sign-extend from inst[31] to XLEN:
  - I-type for op_d[3], [5], [7], [9], [10].
  - S-type for op_d[6].
  - B-type for op_d[4].
  - U-type for op_d[0], [1], as {inst[31:12], 12'b0}.
  - J-type for op_d[2].
  - imm=0 for R-type and unknown opcodes.
- e_inst: exact-word match. ebreak=0x00100073, ecall=0x00000073, mret=0x30200073.
- csr_idx priority:
  - imm[11:0]==CSR_MSTATUS and op_d[9]: 0
  - imm[11:0]==CSR_MTVEC or ecall: 1
  - imm[11:0]==CSR_MEPC or mret: 2
  - otherwise: 3
- Reset asserted mid-stream: entries are discarded immediately; there is no partial output.

Optional Feature:
- Macro: ID_STAGE_ILLEGAL_EN.
- Defined: illegal=1 when op_d is all-zero, when the opcode is RV64-only with XLEN=32, or when an R-type has fu7_d[0..2] all 0. When illegal=1, op_d, e_inst and imm are forced 0.
- Undefined: illegal tied 0 and no forcing.

Test Plan:
- XLEN=64, inst 0xFFF10093 (addi x1,x2,-1) -> rs1=2, rd=1, imm=0xFFFFFFFFFFFFFFFF, op_d=0x080, fu3_d=0x01, one cycle after accept.
- inst 0x800002B7 (lui x5) -> XLEN=64 imm=0xFFFFFFFF80000000, op_d=0x001. XLEN=32 imm=0x80000000.
- inst 0x00000073 -> e_inst=010, csr_idx=1. inst 0x30200073 -> e_inst=100, csr_idx=2. inst 0x30002573 (csrrs mstatus) -> csr_idx=0.
- Stream pcs 0x0,0x4,0x8,0xC with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts. Output order after release is 0x0,0x4,0x8,0xC with no gaps when out_ready=1.
- Two beats held, then flush=1 together with in_valid -> next cycle out_valid=0, in_ready=1, and the flushed beats never appear. Same test with rst_n pulsed low mid-stream -> identical empty state asynchronously.
- With ID_STAGE_ILLEGAL_EN: 0x0000007F -> illegal=1, op_d=0. XLEN=32 with 0x0010809B (addiw) -> illegal=1. Without the macro, illegal stays 0.
